// File: rtl/menu_buttons_if.sv
// VGA stream bundle: raster position, sync/blank flags and 12-bit pixel colour.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/menu_buttons.sv
// menu_buttons: draws N vertically stacked sprite buttons over the VGA stream
// and turns press/release pairs over an enabled button into one-cycle pulses.
module menu_buttons #(
    parameter int          N_BTN     = 3,
    parameter int          BTN_W     = 125,
    parameter int          BTN_H     = 75,
    parameter int          BTN_X0    = 337,
    parameter int          BTN_Y0    = 175,
    parameter int          BTN_GAP   = 25,
    parameter int          ADDR_W    = 14,
    parameter logic [11:0] TRANSP    = 12'h000,
    parameter logic [11:0] HOVER_RGB = 12'hFF0,
    localparam int         SEL_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [N_BTN-1:0]  btn_mask,
    input  logic [11:0]       mouse_x,
    input  logic [11:0]       mouse_y,
    input  logic              mouse_left,
    input  logic [11:0]       rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [SEL_W-1:0]  rom_sel,
    output logic [N_BTN-1:0]  hover,
    output logic [N_BTN-1:0]  btn_pressed,
    vga_if.in                 vga_in,
    vga_if.out                vga_out
);

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    // Per-pixel button tag carried down the pipeline after the ROM address is formed.
    typedef struct packed {
        logic             hit;
        logic [SEL_W-1:0] idx;
        logic             brd;
    } tag_t;

    typedef enum logic [1:0] {WAIT_REL, IDLE, ARMED} state_t;

    function automatic int top_of(input int i);
        return BTN_Y0 + i * (BTN_H + BTN_GAP);
    endfunction

    // Returns {hit, index} of the button covering (x, y).
    function automatic logic [SEL_W:0] find(input logic [11:0] x, input logic [11:0] y);
        logic [SEL_W:0] r;
        r = '0;
        if (int'(x) >= BTN_X0 && int'(x) < BTN_X0 + BTN_W)
            for (int i = 0; i < N_BTN; i++)
                if (int'(y) >= top_of(i) && int'(y) < top_of(i) + BTN_H)
                    r = {1'b1, SEL_W'(i)};
        return r;
    endfunction

    vga_t             v_in, v_out;
    vga_t             v_pipe [1:3];
    tag_t             t_pipe [1:3];
    logic [11:0]      rx1, ry1;
    logic [11:0]      px, py, p_rx, p_ry;
    logic             p_hit, p_brd;
    logic [SEL_W-1:0] p_idx;
    logic [11:0]      rgb_n;

    logic [11:0]      mx, my;
    logic             l1, l2, l3;
    logic             m_hit;
    logic [SEL_W-1:0] m_idx, hov_idx, arm_k, arm_n;
    logic [N_BTN-1:0] hover_n, pulse_n;
    logic             rise, fall;
    state_t           state, state_n;

    assign v_in = '{vga_in.vcount, vga_in.vsync, vga_in.vblnk,
                    vga_in.hcount, vga_in.hsync, vga_in.hblnk, vga_in.rgb};
    assign px   = {1'b0, vga_in.hcount};
    assign py   = {1'b0, vga_in.vcount};

    // S1 hit test on the incoming pixel; relative coordinates stay zero off-button.
    always_comb begin
        {p_hit, p_idx} = find(px, py);
        p_rx  = p_hit ? 12'(int'(px) - BTN_X0) : 12'd0;
        p_ry  = p_hit ? 12'(int'(py) - top_of(int'(p_idx))) : 12'd0;
        p_brd = p_hit && (p_rx < 12'd2 || p_rx >= 12'(BTN_W - 2) ||
                          p_ry < 12'd2 || p_ry >= 12'(BTN_H - 2));
    end

    // Pixel pipeline: S1 capture, S2 ROM address, S3 ROM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= 3; s++) begin
                v_pipe[s] <= '0;
                t_pipe[s] <= '0;
            end
            rx1      <= '0;
            ry1      <= '0;
            rom_addr <= '0;
            rom_sel  <= '0;
        end else begin
            v_pipe[1] <= v_in;
            t_pipe[1] <= '{p_hit, p_idx, p_brd};
            rx1       <= p_rx;
            ry1       <= p_ry;
            for (int s = 2; s <= 3; s++) begin
                v_pipe[s] <= v_pipe[s-1];
                t_pipe[s] <= t_pipe[s-1];
            end
            rom_addr <= t_pipe[1].hit ? ADDR_W'(int'(ry1) * BTN_W + int'(rx1)) : '0;
            rom_sel  <= t_pipe[1].hit ? t_pipe[1].idx : '0;
        end
    end

    // S4 colour selection; border beats transparency, disabled buttons are dimmed.
    always_comb begin
        rgb_n = v_pipe[3].rgb;
        if (enable && t_pipe[3].hit) begin
            if (hover[t_pipe[3].idx] && btn_mask[t_pipe[3].idx] && t_pipe[3].brd)
                rgb_n = HOVER_RGB;
            else if (rom_data == TRANSP)
                rgb_n = v_pipe[3].rgb;
            else if (!btn_mask[t_pipe[3].idx])
                rgb_n = {1'b0, rom_data[11:9], 1'b0, rom_data[7:5], 1'b0, rom_data[3:1]};
            else
                rgb_n = rom_data;
        end
    end

    // S4 output register.
    always_ff @(posedge clk) begin
        if (rst) v_out <= '0;
        else     v_out <= '{v_pipe[3].vcount, v_pipe[3].vsync, v_pipe[3].vblnk,
                            v_pipe[3].hcount, v_pipe[3].hsync, v_pipe[3].hblnk, rgb_n};
    end

    assign vga_out.vcount = v_out.vcount;
    assign vga_out.vsync  = v_out.vsync;
    assign vga_out.vblnk  = v_out.vblnk;
    assign vga_out.hcount = v_out.hcount;
    assign vga_out.hsync  = v_out.hsync;
    assign vga_out.hblnk  = v_out.hblnk;
    assign vga_out.rgb    = v_out.rgb;

    // Hover is decided from the registered cursor.
    always_comb begin
        {m_hit, m_idx} = find(mx, my);
        hover_n = (enable && m_hit && btn_mask[m_idx]) ? N_BTN'(1) << m_idx : '0;
    end

    // Mouse sampling. The button level resets to "held" so that a press in
    // progress across reset has to be released before it can arm anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            mx      <= '0;
            my      <= '0;
            l1      <= 1'b1;
            l2      <= 1'b1;
            l3      <= 1'b1;
            hover   <= '0;
            hov_idx <= '0;
        end else begin
            mx      <= mouse_x;
            my      <= mouse_y;
            l1      <= mouse_left;
            l2      <= l1;
            l3      <= l2;
            hover   <= hover_n;
            hov_idx <= m_idx;
        end
    end

    // Edges come from the level that is aligned with hover.
    assign rise = l2 & ~l3;
    assign fall = ~l2 & l3;

    // Click FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_REL;
            arm_k       <= '0;
            btn_pressed <= '0;
        end else begin
            state       <= state_n;
            arm_k       <= arm_n;
            btn_pressed <= pulse_n;
        end
    end

    // Click FSM next state and pulse.
    always_comb begin
        state_n = state;
        arm_n   = arm_k;
        pulse_n = '0;
        if (!enable) begin
            state_n = WAIT_REL;
        end else begin
            case (state)
                WAIT_REL: if (!l2) state_n = IDLE;
                IDLE: begin
                    if (rise) begin
                        if (|hover) begin
                            state_n = ARMED;
                            arm_n   = hov_idx;
                        end else begin
                            state_n = WAIT_REL;
                        end
                    end
                end
                ARMED: begin
                    if (!btn_mask[arm_k]) begin
                        state_n = WAIT_REL;
                    end else if (fall) begin
                        state_n = IDLE;
                        if (hover[arm_k]) pulse_n = N_BTN'(1) << arm_k;
                    end
                end
                default: state_n = WAIT_REL;
            endcase
        end
    end

endmodule

// File: tb/tb_menu_buttons.sv
// Bench for menu_buttons: directed and random pixels against a geometric model,
// plus press/release episodes judged by the click rules.
module tb_menu_buttons;
    localparam int N = 3, W = 125, H = 75, X0 = 337, Y0 = 175, GAP = 25;

    logic        clk = 1'b0;
    logic        rst, enable, mouse_left;
    logic [2:0]  btn_mask, hover, btn_pressed;
    logic [11:0] mouse_x, mouse_y, rom_data;
    logic [13:0] rom_addr;
    logic [1:0]  rom_sel;
    int          pass_cnt = 0, fail_cnt = 0;
    bit          flat;
    int          px_h[$], px_v[$];
    int          pos_x[5] = '{400, 400, 400, 10, 337};
    int          pos_y[5] = '{212, 300, 412, 10, 276};

    vga_if vin();
    vga_if vout();

    menu_buttons dut (
        .clk(clk), .rst(rst), .enable(enable), .btn_mask(btn_mask),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
        .rom_data(rom_data), .rom_addr(rom_addr), .rom_sel(rom_sel),
        .hover(hover), .btn_pressed(btn_pressed),
        .vga_in(vin), .vga_out(vout)
    );

    always #5 clk = ~clk;

    // Sprite ROM: corner pixel transparent, everything else opaque.
    function automatic logic [11:0] rom_fn(input int sel, input int addr);
        if (addr == 0) return 12'h000;
        if (flat) return 12'h0F0;
        return 12'(addr * 7 + sel * 333) | 12'h800;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(int'(rom_sel), int'(rom_addr));

    function automatic void mloc(input int x, input int y, output bit hit,
                                 output int k, output int rx, output int ry);
        int dy;
        hit = 0; k = 0; rx = 0; ry = 0;
        dy = y - Y0;
        if (x >= X0 && x < X0 + W && dy >= 0 && dy % (H + GAP) < H && dy / (H + GAP) < N) begin
            hit = 1; k = dy / (H + GAP); rx = x - X0; ry = dy % (H + GAP);
        end
    endfunction

    function automatic logic [2:0] mhover(input int x, input int y);
        bit hit; int k, rx, ry;
        mloc(x, y, hit, k, rx, ry);
        return (enable && hit && btn_mask[k]) ? 3'b001 << k : 3'b000;
    endfunction

    function automatic logic [11:0] mpix(input int h, input int v, input logic [11:0] up);
        bit hit; int k, rx, ry; logic [2:0] hv; logic [11:0] d;
        mloc(h, v, hit, k, rx, ry);
        hv = mhover(int'(mouse_x), int'(mouse_y));
        if (!enable || !hit) return up;
        if (hv[k] && (rx < 2 || rx >= W - 2 || ry < 2 || ry >= H - 2)) return 12'hFF0;
        d = rom_fn(k, ry * W + rx);
        if (d == 12'h000) return up;
        if (!btn_mask[k]) return {4'(d[11:8] / 2), 4'(d[7:4] / 2), 4'(d[3:0] / 2)};
        return d;
    endfunction

    function automatic logic [37:0] vout_vec();
        return {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 64'(rom_addr), 0);
        check({tag, "_sel"}, 64'(rom_sel), 0);
        check({tag, "_hover"}, 64'(hover), 0);
        check({tag, "_pressed"}, 64'(btn_pressed), 0);
        check({tag, "_vga"}, 64'(vout_vec()), 0);
    endtask

    // Streams n pixels (queued directed ones first, then random) and checks
    // rom_addr/rom_sel 2 clocks and vga_out 4 clocks after each is presented.
    task automatic run_pixels(input int n);
        logic [15:0] ea[$];
        logic [37:0] ev[$];
        for (int c = 0; c < n + 3; c++) begin
            if (c < n) begin
                int h, v, k, rx, ry; bit hit; logic [11:0] up; logic [3:0] sy;
                if (px_h.size() > 0) begin
                    h = px_h.pop_front(); v = px_v.pop_front();
                end else begin
                    h = $urandom_range(320, 480); v = $urandom_range(160, 460);
                end
                up = 12'($urandom); sy = 4'($urandom);
                vin.hcount = 11'(h); vin.vcount = 11'(v); vin.rgb = up;
                vin.vsync = sy[0]; vin.vblnk = sy[1]; vin.hsync = sy[2]; vin.hblnk = sy[3];
                mloc(h, v, hit, k, rx, ry);
                ea.push_back(hit ? {14'(ry * W + rx), 2'(k)} : 16'h0);
                ev.push_back({11'(v), sy[0], sy[1], 11'(h), sy[2], sy[3], mpix(h, v, up)});
            end
            tick(1);
            if (c >= 1 && c - 1 < n) check("rom_addr_sel", 64'({rom_addr, rom_sel}), 64'(ea.pop_front()));
            if (c >= 3) check("vga_out", 64'(vout_vec()), 64'(ev.pop_front()));
        end
    endtask

    // One press/release episode; mid: 0 none, 2 clear pressed button's mask, 3 drop enable.
    task automatic episode(input int pp, input int rp, input bit enp, input int mid,
                           input logic [2:0] m);
        bit ph, rh; int pk, rk, t0, t1; logic [2:0] ev;
        mloc(pos_x[pp], pos_y[pp], ph, pk, t0, t1);
        mloc(pos_x[rp], pos_y[rp], rh, rk, t0, t1);
        ev = (enp && ph && m[pk] && mid == 0 && rh && rk == pk) ? 3'b001 << pk : 3'b000;
        btn_mask = m; enable = 1'b1; mouse_left = 1'b0;
        mouse_x = 12'(pos_x[pp]); mouse_y = 12'(pos_y[pp]);
        tick(6);
        check("hover_press", 64'(hover), 64'(mhover(pos_x[pp], pos_y[pp])));
        enable = enp; mouse_left = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(1); check("hold_quiet", 64'(btn_pressed), 0); end
        enable = 1'b1;
        if (mid == 2 && ph) btn_mask = m & ~(3'b001 << pk);
        if (mid == 3) enable = 1'b0;
        tick(3);
        btn_mask = m; enable = 1'b1;
        mouse_x = 12'(pos_x[rp]); mouse_y = 12'(pos_y[rp]);
        for (int i = 0; i < 4; i++) begin tick(1); check("move_quiet", 64'(btn_pressed), 0); end
        check("hover_release", 64'(hover), 64'(mhover(pos_x[rp], pos_y[rp])));
        mouse_left = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("btn_pressed", 64'(btn_pressed), (i == 3) ? 64'(ev) : 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; btn_mask = 3'b111; mouse_left = 1'b0;
        mouse_x = 12'd10; mouse_y = 12'd10; flat = 1'b1;
        vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
        vin.vsync = 1'b0; vin.vblnk = 1'b0; vin.hsync = 1'b0; vin.hblnk = 1'b0;
        tick(2);
        check_all_zero("reset");
        rst = 1'b0;
        tick(3);

        // Raster checks with flat ROM: body, transparent corner, button 1 address.
        px_h = '{400, 337, 338}; px_v = '{200, 175, 276};
        run_pixels(40);

        // Button 1 disabled under the cursor: no hover, dimmed sprite.
        btn_mask = 3'b101; mouse_x = 12'd400; mouse_y = 12'd300;
        tick(3);
        check("hover_masked", 64'(hover), 0);
        px_h = '{400, 400}; px_v = '{300, 200};
        run_pixels(20);

        // Random geometry, masks, enable and cursor position with a varied ROM.
        flat = 1'b0;
        for (int p = 0; p < 4; p++) begin
            btn_mask = 3'($urandom); enable = ($urandom_range(0, 3) != 0);
            mouse_x = 12'($urandom_range(320, 480)); mouse_y = 12'($urandom_range(160, 460));
            tick(3);
            check("hover_rand", 64'(hover), 64'(mhover(int'(mouse_x), int'(mouse_y))));
            run_pixels(50);
        end
        enable = 1'b1; btn_mask = 3'b111;

        episode(1, 1, 1, 0, 3'b111);
        episode(0, 1, 1, 0, 3'b111);
        episode(3, 3, 1, 0, 3'b111);
        episode(1, 1, 1, 0, 3'b101);
        episode(1, 1, 0, 0, 3'b111);
        episode(1, 1, 1, 0, 3'b111);
        episode(1, 1, 1, 3, 3'b111);
        episode(1, 1, 1, 2, 3'b111);
        episode(4, 4, 1, 0, 3'b111);
        for (int e = 0; e < 20; e++) begin
            int mids[4] = '{0, 0, 2, 3};
            episode($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3) != 0,
                    mids[$urandom_range(0, 3)], 3'($urandom));
        end

        // Reset while armed: outputs clear, the following release must not click.
        btn_mask = 3'b111; enable = 1'b1; mouse_left = 1'b0;
        mouse_x = 12'd400; mouse_y = 12'd300;
        tick(6);
        mouse_left = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(1);
        check_all_zero("rst_armed");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(1); check("post_rst_hold", 64'(btn_pressed), 0); end
        mouse_left = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(1); check("post_rst_release", 64'(btn_pressed), 0); end
        episode(1, 1, 1, 0, 3'b111);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end
endmodule
